vga_layer_scheduler: RTL and testbench

- Frame-level sequencer and write-port arbiter for the 320x240, 3-bit VGA pixel-write interface.
- On each V_SYNC falling edge it runs enabled drawing engines (background, digit sprites, cursor, ...) one at a time, in fixed index order.
- Each engine gets exclusive, registered access to the shared x/y/color/writeEn port until it reports done.
- Sits between the drawing engines and the VGA adapter write port.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_next_layer.sv | 38 +++
 rtl/vga_layer_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_vga_layer_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA screen constants and layer scheduler state encoding
//
// Purpose: common constants for the 320x240, 3-bit pixel-write interface and
//          the state encoding used by vga_layer_scheduler.
// Ports:   none (package).

package vga_pkg;

  localparam int SCR_W   = 320;
  localparam int SCR_H   = 240;
  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int COLOR_W = 3;

  localparam logic [1:0] SCHED_IDLE  = 2'd0;
  localparam logic [1:0] SCHED_START = 2'd1;
  localparam logic [1:0] SCHED_DRAW  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = SCHED_IDLE,
    ST_START = SCHED_START,
    ST_DRAW  = SCHED_DRAW
  } sched_state_t;

endpackage

// File: rtl/vga_next_layer.sv
// rtl/vga_next_layer.sv - lowest enabled layer above a given index
//
// Purpose: combinational finder returning the lowest set bit of mask whose
//          position is strictly above cur. With from_start high, cur is
//          ignored and the search covers the whole mask (the "index -1" case).
// Ports:
//   mask        in   N_LAYERS  enabled layers
//   cur         in   IDX_W     current layer index
//   from_start  in   1         search from below bit 0
//   valid       out  1         a qualifying layer exists
//   idx         out  IDX_W     its index (0 when valid is low)

module vga_next_layer
  import vga_pkg::*;
#(
  parameter int N_LAYERS = 3,
  parameter int IDX_W    = 2
) (
  input  logic [N_LAYERS-1:0] mask,
  input  logic [IDX_W-1:0]    cur,
  input  logic                from_start,
  output logic                valid,
  output logic [IDX_W-1:0]    idx
);

  // Scan downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/vga_layer_scheduler.sv
// rtl/vga_layer_scheduler.sv - frame sequencer and write-port arbiter for drawing layers
//
// Purpose: on every V_SYNC falling edge, starts the enabled drawing engines one
//          at a time in index order and gives the running one registered,
//          exclusive use of the shared x/y/color/writeEn pixel port.
// Optional: define VGA_SCHED_WDOG_EN to abort a layer that holds the port for
//           WDOG_CYCLES draw cycles and to add the sticky oTimeout flag.
// Ports:
//   clk, iResetn        clock, synchronous active-low reset
//   V_SYNC              falling edge starts a frame
//   iLayerEn            per-layer enable, sampled at frame start
//   iX/iY/iColor/iWe    per-layer pixel write slices
//   iDone               per-layer completion pulse
//   iClrOverrun         clears oOverrun (and oTimeout)
//   oStart              one-cycle start pulse to the selected layer
//   x/y/color/writeEn   registered pixel port
//   oBusy, oActive      frame in progress, owning layer index
//   oOverrun            sticky, a frame start was dropped
//   oFrameCount         completed frames, wrapping
//   oTimeout            (VGA_SCHED_WDOG_EN only) sticky, a layer was aborted

module vga_layer_scheduler
  import vga_pkg::*;
#(
  parameter int N_LAYERS    = 3,
  parameter int WDOG_CYCLES = 131072
) (
  input  logic                         clk,
  input  logic                         iResetn,
  input  logic                         V_SYNC,
  input  logic [N_LAYERS-1:0]          iLayerEn,
  input  logic [X_W*N_LAYERS-1:0]      iX,
  input  logic [Y_W*N_LAYERS-1:0]      iY,
  input  logic [COLOR_W*N_LAYERS-1:0]  iColor,
  input  logic [N_LAYERS-1:0]          iWe,
  input  logic [N_LAYERS-1:0]          iDone,
  input  logic                         iClrOverrun,
  output logic [N_LAYERS-1:0]          oStart,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOR_W-1:0]           color,
  output logic                         writeEn,
  output logic                         oBusy,
  output logic [$clog2(N_LAYERS)-1:0]  oActive,
  output logic                         oOverrun,
  output logic [15:0]                  oFrameCount
`ifdef VGA_SCHED_WDOG_EN
  ,
  output logic                         oTimeout
`endif
);

  localparam int IDX_W = $clog2(N_LAYERS);

  sched_state_t        state, state_next;
  logic                vsync_prev;
  logic                frame_edge;
  logic [N_LAYERS-1:0] mask;
  logic [IDX_W-1:0]    idx;
  logic                sel_we;
  logic                sel_done;
  logic                wdog_hit;
  logic                nl_valid;
  logic [IDX_W-1:0]    nl_idx;
  logic                in_idle;
  logic                frame_done;
  logic                take_idx;

  assign frame_edge = !V_SYNC && vsync_prev;
  assign in_idle    = (state == ST_IDLE);
  assign sel_we     = iWe[idx];
  assign sel_done   = iDone[idx] | wdog_hit;

  // One finder serves both uses: in IDLE it scans the live enables from the
  // bottom, otherwise it scans the latched mask above the current layer.
  vga_next_layer #(
    .N_LAYERS (N_LAYERS),
    .IDX_W    (IDX_W)
  ) u_next (
    .mask       (in_idle ? iLayerEn : mask),
    .cur        (idx),
    .from_start (in_idle),
    .valid      (nl_valid),
    .idx        (nl_idx)
  );

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    oStart     = '0;
    frame_done = 1'b0;
    take_idx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_edge) begin
          if (nl_valid) begin
            state_next = ST_START;
            take_idx   = 1'b1;
          end else begin
            frame_done = 1'b1;
          end
        end
      end
      ST_START: begin
        oStart[idx] = 1'b1;
        state_next  = ST_DRAW;
      end
      ST_DRAW: begin
        if (sel_done) begin
          if (nl_valid) begin
            state_next = ST_START;
            take_idx   = 1'b1;
          end else begin
            state_next = ST_IDLE;
            frame_done = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      vsync_prev  <= 1'b1;
      mask        <= '0;
      idx         <= '0;
      oActive     <= '0;
      x           <= '0;
      y           <= '0;
      color       <= '0;
      writeEn     <= 1'b0;
      oBusy       <= 1'b0;
      oOverrun    <= 1'b0;
      oFrameCount <= '0;
    end else begin
      vsync_prev <= V_SYNC;
      if (in_idle && frame_edge) begin
        mask <= iLayerEn;
      end
      if (take_idx) begin
        idx <= nl_idx;
      end
      if (state == ST_START) begin
        oActive <= idx;
      end
      // The done-cycle write is still forwarded because DRAW is the current state.
      writeEn <= (state == ST_DRAW) && sel_we;
      if ((state == ST_DRAW) && sel_we) begin
        x     <= iX[idx*X_W +: X_W];
        y     <= iY[idx*Y_W +: Y_W];
        color <= iColor[idx*COLOR_W +: COLOR_W];
      end
      oBusy <= (state_next != ST_IDLE);
      if (frame_edge && !in_idle) begin
        oOverrun <= 1'b1;
      end else if (iClrOverrun) begin
        oOverrun <= 1'b0;
      end
      if (frame_done) begin
        oFrameCount <= oFrameCount + 16'd1;
      end
    end
  end

`ifdef VGA_SCHED_WDOG_EN
  logic [16:0] wdog_cnt;

  assign wdog_hit = (state == ST_DRAW) && (wdog_cnt == 17'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!iResetn) begin
      wdog_cnt <= '0;
      oTimeout <= 1'b0;
    end else begin
      if (state == ST_START) begin
        wdog_cnt <= '0;
      end else if (state == ST_DRAW) begin
        wdog_cnt <= wdog_cnt + 17'd1;
      end
      // A genuine done in the expiry cycle is not a timeout.
      if (wdog_hit && !iDone[idx]) begin
        oTimeout <= 1'b1;
      end else if (iClrOverrun) begin
        oTimeout <= 1'b0;
      end
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

endmodule

// File: tb/tb_vga_layer_scheduler.sv
// tb/tb_vga_layer_scheduler.sv - self-checking bench for vga_layer_scheduler
module tb_vga_layer_scheduler;
  import vga_pkg::*;

  localparam int N = 3;
`ifdef VGA_SCHED_WDOG_EN
  localparam int WDOG = 16;
`else
  localparam int WDOG = 131072;
`endif
  localparam int PW = X_W + Y_W + COLOR_W;

  logic                 clk = 1'b0;
  logic                 iResetn;
  logic                 V_SYNC;
  logic                 iClrOverrun;
  logic [N-1:0]         iLayerEn, iWe, iDone, oStart;
  logic [X_W*N-1:0]     iX;
  logic [Y_W*N-1:0]     iY;
  logic [COLOR_W*N-1:0] iColor;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic [COLOR_W-1:0]   color;
  logic                 writeEn, oBusy, oOverrun;
  logic [1:0]           oActive;
  logic [15:0]          oFrameCount;
`ifdef VGA_SCHED_WDOG_EN
  logic                 oTimeout;
`endif

  int checks = 0;
  int errors = 0;
  int fc_exp = 0;
  logic [PW-1:0] last_pix = '0;

  vga_layer_scheduler #(.N_LAYERS(N), .WDOG_CYCLES(WDOG)) dut (
    .clk         (clk),
    .iResetn     (iResetn),
    .V_SYNC      (V_SYNC),
    .iLayerEn    (iLayerEn),
    .iX          (iX),
    .iY          (iY),
    .iColor      (iColor),
    .iWe         (iWe),
    .iDone       (iDone),
    .iClrOverrun (iClrOverrun),
    .oStart      (oStart),
    .x           (x),
    .y           (y),
    .color       (color),
    .writeEn     (writeEn),
    .oBusy       (oBusy),
    .oActive     (oActive),
    .oOverrun    (oOverrun),
    .oFrameCount (oFrameCount)
`ifdef VGA_SCHED_WDOG_EN
    ,
    .oTimeout    (oTimeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iWe = '0; iDone = '0; iClrOverrun = 1'b0;
    iX = '0; iY = '0; iColor = '0;
  endtask

  // Non-selected layers constantly try to write x=77 and raise random done.
  task automatic drive_others(input int k);
    for (int m = 0; m < N; m++) begin
      if (m != k) begin
        iWe[m] = 1'b1;
        iDone[m] = 1'($urandom_range(0, 1));
        iX[m*X_W +: X_W] = X_W'(77);
        iY[m*Y_W +: Y_W] = Y_W'($urandom_range(0, SCR_H - 1));
        iColor[m*COLOR_W +: COLOR_W] = COLOR_W'($urandom);
      end
    end
  endtask

  // Runs one frame: each enabled layer (ascending) writes its pixels then
  // reports done; every cycle's port value is predicted from what was driven.
  task automatic run_frame(input logic [N-1:0] en, input int npx_max, input bit exact);
    int order[$];
    for (int k = 0; k < N; k++) if (en[k]) order.push_back(k);
    idle_inputs();
    iLayerEn = en;
    V_SYNC = 1'b0;
    step();
    V_SYNC = 1'b1;
    if (order.size() == 0) begin
      fc_exp++;
      checks++;
      if (oStart !== '0 || oBusy !== 1'b0 || oFrameCount !== 16'(fc_exp)) begin
        errors++;
        $display("FAIL empty_frame start=%b busy=%b count=%0d expected start=0 busy=0 count=%0d",
                 oStart, oBusy, oFrameCount, fc_exp);
      end
      step();
      return;
    end
    foreach (order[p]) begin
      int k;
      int left;
      int gaps;
      bit fin;
      bit drove;
      logic [PW-1:0] pix;
      k = order[p];
      checks++;
      if (oStart !== N'(1 << k) || oBusy !== 1'b1) begin
        errors++;
        $display("FAIL layer_start start=%b busy=%b expected start=%b busy=1", oStart, oBusy, N'(1 << k));
      end
      iLayerEn = N'($urandom);
      idle_inputs();
      drive_others(k);
      step();
      checks++;
      if (oActive !== 2'(k) || oStart !== '0 || writeEn !== 1'b0 || oBusy !== 1'b1) begin
        errors++;
        $display("FAIL first_draw active=%0d start=%b we=%b busy=%b expected active=%0d start=0 we=0 busy=1",
                 oActive, oStart, writeEn, oBusy, k);
      end
      left = exact ? npx_max : $urandom_range(1, npx_max);
      gaps = 0;
      fin = 1'b0;
      pix = '0;
      while (!fin) begin
        idle_inputs();
        drive_others(k);
        drove = 1'b0;
        if (left > 0 && (gaps >= 2 || $urandom_range(0, 2) != 0)) begin
          pix = {X_W'($urandom_range(100, SCR_W - 1)), Y_W'($urandom_range(0, SCR_H - 1)), COLOR_W'($urandom)};
          iWe[k] = 1'b1;
          iX[k*X_W +: X_W] = pix[PW-1 -: X_W];
          iY[k*Y_W +: Y_W] = pix[COLOR_W +: Y_W];
          iColor[k*COLOR_W +: COLOR_W] = pix[COLOR_W-1:0];
          drove = 1'b1;
          left--;
        end else if (left > 0) begin
          gaps++;
        end
        if (left == 0 && (!drove || $urandom_range(0, 1) == 1)) begin
          iDone[k] = 1'b1;
          fin = 1'b1;
        end
        step();
        checks++;
        if (drove) begin
          if ({writeEn, x, y, color} !== {1'b1, pix}) begin
            errors++;
            $display("FAIL pixel layer=%0d got we=%b x=%0d y=%0d c=%0d expected we=1 x=%0d y=%0d c=%0d",
                     k, writeEn, x, y, color, pix[PW-1 -: X_W], pix[COLOR_W +: Y_W], pix[COLOR_W-1:0]);
          end
          last_pix = pix;
        end else if ({writeEn, x, y, color} !== {1'b0, last_pix}) begin
          errors++;
          $display("FAIL hold layer=%0d got we=%b x=%0d y=%0d c=%0d expected we=0 x=%0d y=%0d c=%0d",
                   k, writeEn, x, y, color, last_pix[PW-1 -: X_W], last_pix[COLOR_W +: Y_W], last_pix[COLOR_W-1:0]);
        end
      end
    end
    fc_exp++;
    idle_inputs();
    checks++;
    if (oStart !== '0 || oBusy !== 1'b0 || oFrameCount !== 16'(fc_exp)) begin
      errors++;
      $display("FAIL frame_end start=%b busy=%b count=%0d expected start=0 busy=0 count=%0d",
               oStart, oBusy, oFrameCount, fc_exp);
    end
    step();
    checks++;
    if (writeEn !== 1'b0 || oBusy !== 1'b0 || oStart !== '0) begin
      errors++;
      $display("FAIL after_frame we=%b busy=%b start=%b expected all 0", writeEn, oBusy, oStart);
    end
  endtask

  task automatic test_reset();
    iResetn = 1'b0;
    step();
    step();
    checks++;
    if ({oStart, x, y, color, writeEn, oBusy, oActive, oOverrun, oFrameCount} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0",
               {oStart, x, y, color, writeEn, oBusy, oActive, oOverrun, oFrameCount});
    end
    iResetn = 1'b1;
    step();
    checks++;
    if (oStart !== '0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release start=%b busy=%b expected 0 0", oStart, oBusy);
    end
  endtask

  task automatic test_all_layers();
    run_frame(3'b111, 3, 1'b1);
  endtask

  task automatic test_skip_layer();
    run_frame(3'b101, 3, 1'b0);
  endtask

  task automatic test_empty_frames();
    run_frame(3'b000, 1, 1'b0);
    run_frame(3'b000, 1, 1'b0);
  endtask

  task automatic test_overrun();
    idle_inputs();
    iLayerEn = 3'b001; V_SYNC = 1'b0;
    step();
    V_SYNC = 1'b1;
    step();
    V_SYNC = 1'b0;
    step();
    checks++;
    if (oOverrun !== 1'b1 || oBusy !== 1'b1 || oStart !== '0) begin
      errors++;
      $display("FAIL overrun_set ovr=%b busy=%b start=%b expected 1 1 000", oOverrun, oBusy, oStart);
    end
    V_SYNC = 1'b1;
    step();
    checks++;
    if (oStart !== '0 || oActive !== 2'd0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_no_restart start=%b active=%0d busy=%b expected 000 0 1", oStart, oActive, oBusy);
    end
    iDone[0] = 1'b1;
    step();
    iDone = '0;
    fc_exp++;
    checks++;
    if (oBusy !== 1'b0 || oFrameCount !== 16'(fc_exp) || oOverrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_complete busy=%b count=%0d ovr=%b expected 0 %0d 1", oBusy, oFrameCount, oOverrun, fc_exp);
    end
    step();
    iClrOverrun = 1'b1;
    step();
    iClrOverrun = 1'b0;
    checks++;
    if (oOverrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear ovr=%b expected 0", oOverrun);
    end
    // Edge on the final done, with a clear in the same cycle.
    iLayerEn = 3'b001; V_SYNC = 1'b0;
    step();
    V_SYNC = 1'b1;
    step();
    iDone[0] = 1'b1; V_SYNC = 1'b0; iClrOverrun = 1'b1;
    step();
    fc_exp++;
    checks++;
    if (oOverrun !== 1'b1 || oBusy !== 1'b0 || oFrameCount !== 16'(fc_exp)) begin
      errors++;
      $display("FAIL overrun_set_wins ovr=%b busy=%b count=%0d expected 1 0 %0d", oOverrun, oBusy, oFrameCount, fc_exp);
    end
    iDone = '0; iClrOverrun = 1'b0;
    step();
    checks++;
    if (oStart !== '0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_done_edge start=%b busy=%b expected 000 0", oStart, oBusy);
    end
    V_SYNC = 1'b1; iClrOverrun = 1'b1;
    step();
    iClrOverrun = 1'b0;
    checks++;
    if (oOverrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear2 ovr=%b expected 0", oOverrun);
    end
  endtask

  task automatic test_reset_mid_draw();
    idle_inputs();
    iLayerEn = 3'b111; V_SYNC = 1'b0;
    step();
    V_SYNC = 1'b1;
    step();
    iWe[0] = 1'b1; iX[X_W-1:0] = X_W'(123); iY[Y_W-1:0] = Y_W'(45); iColor[COLOR_W-1:0] = 3'd5;
    step();
    iResetn = 1'b0;
    step();
    checks++;
    if ({oStart, x, y, color, writeEn, oBusy, oActive, oOverrun, oFrameCount} !== '0) begin
      errors++;
      $display("FAIL reset_mid_draw got %h expected 0",
               {oStart, x, y, color, writeEn, oBusy, oActive, oOverrun, oFrameCount});
    end
    iResetn = 1'b1; iWe = 3'b111;
    fc_exp = 0;
    last_pix = '0;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (writeEn !== 1'b0 || oStart !== '0 || oBusy !== 1'b0) begin
        errors++;
        $display("FAIL reset_abandon we=%b start=%b busy=%b expected 0 000 0", writeEn, oStart, oBusy);
      end
    end
    idle_inputs();
    step();
    run_frame(3'b111, 2, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      run_frame(N'($urandom), $urandom_range(1, 4), 1'b0);
    end
  endtask

`ifdef VGA_SCHED_WDOG_EN
  task automatic test_watchdog();
    int n;
    checks++;
    if (oTimeout !== 1'b0) begin
      errors++;
      $display("FAIL wdog_initial timeout=%b expected 0", oTimeout);
    end
    idle_inputs();
    iLayerEn = 3'b111; V_SYNC = 1'b0;
    step();
    V_SYNC = 1'b1;
    step();
    iDone[0] = 1'b1;
    step();
    iDone = '0;
    checks++;
    if (oStart !== 3'b010) begin
      errors++;
      $display("FAIL wdog_layer1_start start=%b expected 010", oStart);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (oStart !== 3'b100 && n < 40);
    checks++;
    if (n !== 17 || oTimeout !== 1'b1) begin
      errors++;
      $display("FAIL wdog_abort steps=%0d timeout=%b expected 17 1", n, oTimeout);
    end
    step();
    iDone[2] = 1'b1;
    step();
    iDone = '0;
    fc_exp++;
    checks++;
    if (oBusy !== 1'b0 || oFrameCount !== 16'(fc_exp)) begin
      errors++;
      $display("FAIL wdog_frame_end busy=%b count=%0d expected 0 %0d", oBusy, oFrameCount, fc_exp);
    end
    iClrOverrun = 1'b1;
    step();
    iClrOverrun = 1'b0;
    checks++;
    if (oTimeout !== 1'b0) begin
      errors++;
      $display("FAIL wdog_clear timeout=%b expected 0", oTimeout);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    iResetn = 1'b0;
    V_SYNC = 1'b1;
    iLayerEn = '0;
    idle_inputs();
    test_reset();
    test_all_layers();
    test_skip_layer();
    test_empty_frames();
    test_overrun();
    test_reset_mid_draw();
    test_random_frames();
`ifdef VGA_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
